// File: rtl/rv32i_fetch_unit.sv
// rv32i_fetch_unit
//
// Instruction-fetch initiator for rv32i_core. Issues sequential word fetches on
// the instr req/gnt/rvalid interface, buffers returned words with their PCs in a
// small FIFO and hands them to decode over a valid/ready interface. A redirect
// flushes the buffer and drops the responses of every fetch already in flight.
//
// Parameters:
//   BOOT_ADDR        first fetch address after reset (word aligned)
//   FIFO_DEPTH       instruction buffer entries (power of two, >= 2)
//   MAX_OUTSTANDING  granted-but-unanswered fetch limit (<= FIFO_DEPTH)
//
// Ports:
//   clk, rst_ni                clock, asynchronous active-low reset
//   fetch_en_i                 permit issuing new fetches
//   redirect_i, redirect_pc_i  one-cycle redirect strobe and target PC
//   instr_req_o/gnt_i/addr_o   fetch request channel
//   instr_rvalid_i/rdata_i     fetch response channel (in order)
//   instr_valid_o/ready_i      decode handshake for the buffer head
//   instr_rdata_o, instr_pc_o  head instruction word and its PC
//   perf_fetch_cnt_o           delivered instructions
//   perf_discard_cnt_o         dropped responses plus flushed entries
//
// Optional feature: define IFU_PERF_CNT_EN to build the two performance
// counters; otherwise both perf outputs are tied to zero.

module rv32i_fetch_unit #(
    parameter logic [31:0] BOOT_ADDR       = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_ni,
    input  logic        fetch_en_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_req_o,
    input  logic        instr_gnt_i,
    output logic [31:0] instr_addr_o,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_rdata_o,
    output logic [31:0] instr_pc_o,
    output logic [31:0] perf_fetch_cnt_o,
    output logic [31:0] perf_discard_cnt_o
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);

    // Request channel state. req_addr_q is the address on the bus; fetch_pc_q
    // is the address the next launched request will carry. Keeping them apart
    // lets a redirect retarget fetch_pc_q while an ungranted request holds its
    // old address.
    logic            req_q, req_d;
    logic [31:0]     req_addr_q, req_addr_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    // Set while the pending ungranted request predates a redirect.
    logic            stale_q, stale_d;

    // Response tracking.
    logic [OutW-1:0] outst_q, outst_d;
    logic [OutW-1:0] discard_q, discard_d;
    logic [31:0]     resp_pc_q, resp_pc_d;

    // Instruction buffer.
    logic [31:0]     data_mem_q [FIFO_DEPTH];
    logic [31:0]     pc_mem_q   [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic            accept;
    logic            rvalid_ok;
    logic            drop;
    logic            push;
    logic            pop;
    logic            can_issue;
    logic            launch;
    logic [31:0]     redirect_pc;

    logic            unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc_i[1:0];

    assign redirect_pc = {redirect_pc_i[31:2], 2'b00};

    // Handshake qualifiers. An rvalid with nothing outstanding is a protocol
    // error (e.g. a late response after reset) and is ignored entirely.
    always_comb begin
        accept    = req_q && instr_gnt_i;
        rvalid_ok = instr_rvalid_i && (outst_q != '0);
        drop      = rvalid_ok && ((discard_q != '0) || redirect_i);
        push      = rvalid_ok && !drop;
        pop       = instr_valid_o && instr_ready_i && !redirect_i;
    end

    // Outstanding count and discard bookkeeping.
    always_comb begin
        outst_d   = outst_q;
        discard_d = discard_q;
        stale_d   = stale_q;

        if (accept && !rvalid_ok) begin
            outst_d = outst_q + OutW'(1);
        end else if (!accept && rvalid_ok) begin
            outst_d = outst_q - OutW'(1);
        end

        if (rvalid_ok && (discard_q != '0)) begin
            discard_d = discard_q - OutW'(1);
        end
        if (accept && stale_q) begin
            discard_d = discard_d + OutW'(1);
            stale_d   = 1'b0;
        end

        // Everything in flight after this cycle belongs to the old stream,
        // including a fetch granted in this very cycle.
        if (redirect_i) begin
            discard_d = outst_d;
            stale_d   = req_q && !instr_gnt_i;
        end
    end

    // FIFO pointers and occupancy; a redirect flushes and wins over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (redirect_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                cnt_d = cnt_q + CntW'(1);
            end else if (!push && pop) begin
                cnt_d = cnt_q - CntW'(1);
            end
        end
    end

    // Response PC tracks the next word that will be pushed.
    always_comb begin
        resp_pc_d = resp_pc_q;
        if (redirect_i) begin
            resp_pc_d = redirect_pc;
        end else if (push) begin
            resp_pc_d = resp_pc_q + 32'd4;
        end
    end

    // Request launch. The condition is evaluated on post-update counts so the
    // request about to appear on the bus always has both an outstanding slot
    // and a reserved buffer entry once granted.
    always_comb begin
        can_issue = fetch_en_i
                    && (32'(outst_d) < MAX_OUTSTANDING)
                    && ((32'(cnt_d) + 32'(outst_d)) < FIFO_DEPTH);
        launch    = (!req_q || accept) && can_issue;

        req_d      = req_q && !accept;
        req_addr_d = req_addr_q;
        fetch_pc_d = redirect_i ? redirect_pc : fetch_pc_q;

        if (launch) begin
            req_d      = 1'b1;
            req_addr_d = redirect_i ? redirect_pc : fetch_pc_q;
            fetch_pc_d = req_addr_d + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q      <= 1'b0;
            req_addr_q <= BOOT_ADDR;
            fetch_pc_q <= BOOT_ADDR;
            stale_q    <= 1'b0;
            outst_q    <= '0;
            discard_q  <= '0;
            resp_pc_q  <= BOOT_ADDR;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            req_q      <= req_d;
            req_addr_q <= req_addr_d;
            fetch_pc_q <= fetch_pc_d;
            stale_q    <= stale_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            resp_pc_q  <= resp_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    // Buffer storage needs no reset: entries are only observed while counted.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem_q[wr_ptr_q] <= instr_rdata_i;
            pc_mem_q[wr_ptr_q]   <= resp_pc_q;
        end
    end

    always_comb begin
        instr_req_o   = req_q;
        instr_addr_o  = req_addr_q;
        instr_valid_o = (cnt_q != '0);
        instr_rdata_o = instr_valid_o ? data_mem_q[rd_ptr_q] : 32'h0;
        instr_pc_o    = instr_valid_o ? pc_mem_q[rd_ptr_q]   : 32'h0;
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_discard_q, perf_discard_d;

    always_comb begin
        perf_fetch_d   = perf_fetch_q + {31'd0, pop};
        perf_discard_d = perf_discard_q + {31'd0, drop};
        if (redirect_i) begin
            perf_discard_d = perf_discard_d + 32'(cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_fetch_q   <= 32'h0;
            perf_discard_q <= 32'h0;
        end else begin
            perf_fetch_q   <= perf_fetch_d;
            perf_discard_q <= perf_discard_d;
        end
    end

    assign perf_fetch_cnt_o   = perf_fetch_q;
    assign perf_discard_cnt_o = perf_discard_q;
`else
    assign perf_fetch_cnt_o   = 32'h0;
    assign perf_discard_cnt_o = 32'h0;
`endif

endmodule
